// File: rtl/acq_sequencer.sv
// acq_sequencer: start/stop driven master sequencer for the I/Q receive chain
// (AGC SPI load, ADC control load, settle, acquire). Macro ACQ_SEQ_FRAME_LIMIT_EN adds the nsamples frame limit.
module acq_sequencer #(
   parameter int SETTLE_CYCLES = 100,
   parameter int AGC_TIMEOUT   = 4096,
   parameter int WRCNT_WIDTH   = 11,
   parameter int FIFO_HWM      = 1920
) (
   input  logic                   clk,
   input  logic                   arstn,
   input  logic                   start,
   input  logic                   stop,
   input  logic [11:0]            agc_level,
   input  logic [9:0]             ctrlword,
   input  logic [31:0]            nsamples,
   input  logic                   agc_csn,
   input  logic [1:0]             adc_mbusy,
   input  logic                   adc_valid,
   input  logic [WRCNT_WIDTH-1:0] fifo_wrcnt,
   output logic [11:0]            agc_data,
   output logic                   agc_load,
   output logic [9:0]             adc_ctrlword,
   output logic                   adc_ldctrl,
   output logic                   adc_enable,
   output logic                   busy,
   output logic                   overrun,
   output logic                   agc_err,
   output logic [31:0]            sample_cnt,
   output logic [2:0]             dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_AGC_LOAD = 3'd1,
      S_AGC_WAIT = 3'd2,
      S_ADC_CFG  = 3'd3,
      S_ADC_WAIT = 3'd4,
      S_SETTLE   = 3'd5,
      S_ACQUIRE  = 3'd6
   } state_t;

   localparam logic [31:0]            L_TMO_LAST    = 32'(AGC_TIMEOUT - 1);
   localparam logic [31:0]            L_SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
   localparam logic [WRCNT_WIDTH-1:0] L_HWM         = WRCNT_WIDTH'(FIFO_HWM);

   state_t      r_state;
   logic [31:0] r_cnt;
   logic        r_seen_low;
   logic [11:0] r_agc_data;
   logic [9:0]  r_ctrlword;
   logic        r_agc_load;
   logic        r_ldctrl;
   logic        r_enable;
   logic        r_busy;
   logic        r_overrun;
   logic        r_agc_err;
   logic [31:0] r_sample_cnt;
   logic [31:0] w_cnt_inc;
   logic        w_limit_hit;

   // start/stop are single-cycle commands sampled on the rising edge; adc_valid
   // is a per-cycle strobe with no back-pressure, so every sampled strobe counts.
   assign w_cnt_inc = (r_sample_cnt == 32'hFFFF_FFFF) ? r_sample_cnt : r_sample_cnt + 32'd1;

`ifdef ACQ_SEQ_FRAME_LIMIT_EN
   logic [31:0] r_nsamples;
   assign w_limit_hit = adc_valid && (r_nsamples != 32'd0) && (w_cnt_inc == r_nsamples);
`else
   logic w_unused_nsamples;
   assign w_unused_nsamples = ^nsamples;
   assign w_limit_hit       = 1'b0;
`endif

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         r_state      <= S_IDLE;
         r_cnt        <= 32'd0;
         r_seen_low   <= 1'b0;
         r_agc_data   <= 12'hAAA;
         r_ctrlword   <= 10'b0000100100;
         r_agc_load   <= 1'b0;
         r_ldctrl     <= 1'b0;
         r_enable     <= 1'b0;
         r_busy       <= 1'b0;
         r_overrun    <= 1'b0;
         r_agc_err    <= 1'b0;
         r_sample_cnt <= 32'd0;
`ifdef ACQ_SEQ_FRAME_LIMIT_EN
         r_nsamples   <= 32'd0;
`endif
      end else begin
         r_agc_load <= 1'b0;
         r_ldctrl   <= 1'b0;
         if (stop && (r_state != S_IDLE)) begin
            // Abort from anywhere: flags survive, a strobe in the stop cycle still counts.
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_enable <= 1'b0;
            if ((r_state == S_ACQUIRE) && adc_valid) r_sample_cnt <= w_cnt_inc;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start && !stop) begin
                     r_agc_data   <= agc_level;
                     r_ctrlword   <= ctrlword;
                     r_sample_cnt <= 32'd0;
                     r_overrun    <= 1'b0;
                     r_agc_err    <= 1'b0;
`ifdef ACQ_SEQ_FRAME_LIMIT_EN
                     r_nsamples   <= nsamples;
`endif
                     r_agc_load   <= 1'b1;
                     r_busy       <= 1'b1;
                     r_state      <= S_AGC_LOAD;
                  end
               end
               S_AGC_LOAD: begin
                  r_cnt      <= 32'd0;
                  r_seen_low <= 1'b0;
                  r_state    <= S_AGC_WAIT;
               end
               S_AGC_WAIT: begin
                  if (r_seen_low && agc_csn) begin
                     r_ldctrl <= 1'b1;
                     r_state  <= S_ADC_CFG;
                  end else if (r_cnt == L_TMO_LAST) begin
                     r_agc_err <= 1'b1;
                     r_busy    <= 1'b0;
                     r_state   <= S_IDLE;
                  end else begin
                     r_cnt <= r_cnt + 32'd1;
                     if (!agc_csn) r_seen_low <= 1'b1;
                  end
               end
               S_ADC_CFG: begin
                  r_cnt   <= 32'd0;
                  r_state <= S_ADC_WAIT;
               end
               S_ADC_WAIT: begin
                  // r_cnt only marks that the first ADC_WAIT cycle has passed.
                  if ((r_cnt != 32'd0) && (adc_mbusy == 2'b00)) begin
                     r_cnt   <= 32'd0;
                     r_state <= S_SETTLE;
                  end else begin
                     r_cnt <= 32'd1;
                  end
               end
               S_SETTLE: begin
                  if (r_cnt == L_SETTLE_LAST) begin
                     r_enable <= 1'b1;
                     r_state  <= S_ACQUIRE;
                  end else begin
                     r_cnt <= r_cnt + 32'd1;
                  end
               end
               S_ACQUIRE: begin
                  if (adc_valid) r_sample_cnt <= w_cnt_inc;
                  if (fifo_wrcnt >= L_HWM) begin
                     r_overrun <= 1'b1;
                     r_enable  <= 1'b0;
                     r_busy    <= 1'b0;
                     r_state   <= S_IDLE;
                  end else if (w_limit_hit) begin
                     r_enable <= 1'b0;
                     r_busy   <= 1'b0;
                     r_state  <= S_IDLE;
                  end
               end
               default: begin
                  r_enable <= 1'b0;
                  r_busy   <= 1'b0;
                  r_state  <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign agc_data     = r_agc_data;
   assign agc_load     = r_agc_load;
   assign adc_ctrlword = r_ctrlword;
   assign adc_ldctrl   = r_ldctrl;
   assign adc_enable   = r_enable;
   assign busy         = r_busy;
   assign overrun      = r_overrun;
   assign agc_err      = r_agc_err;
   assign sample_cnt   = r_sample_cnt;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed-plus-random bench for acq_sequencer: expected timing and counts come
// from the sequencing rules (cycle arithmetic, strobe tallies, a word queue).
module tb_acq_sequencer;

   localparam int SETTLE = 10;
   localparam int TMO    = 64;
   localparam int WW     = 11;
   localparam int HWM    = 1920;

   logic          clk = 1'b0;
   logic          arstn = 1'b1;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [11:0]   agc_level = 12'h000;
   logic [9:0]    ctrlword = 10'h000;
   logic [31:0]   nsamples = 32'd0;
   logic          agc_csn = 1'b1;
   logic [1:0]    adc_mbusy = 2'b00;
   logic          adc_valid = 1'b0;
   logic [WW-1:0] fifo_wrcnt = '0;
   logic [11:0]   agc_data;
   logic          agc_load;
   logic [9:0]    adc_ctrlword;
   logic          adc_ldctrl;
   logic          adc_enable;
   logic          busy;
   logic          overrun;
   logic          agc_err;
   logic [31:0]   sample_cnt;
   logic [2:0]    dbg_state;

   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;
   int n_load = 0;
   int n_ldctrl = 0;
   logic [11:0] mon_agc = 12'h000;
   logic [9:0]  mon_cw = 10'h000;
   logic [21:0] exp_q[$];
   int          exp_cnt;

   acq_sequencer #(
      .SETTLE_CYCLES(SETTLE),
      .AGC_TIMEOUT  (TMO),
      .WRCNT_WIDTH  (WW),
      .FIFO_HWM     (HWM)
   ) dut (
      .clk         (clk),
      .arstn       (arstn),
      .start       (start),
      .stop        (stop),
      .agc_level   (agc_level),
      .ctrlword    (ctrlword),
      .nsamples    (nsamples),
      .agc_csn     (agc_csn),
      .adc_mbusy   (adc_mbusy),
      .adc_valid   (adc_valid),
      .fifo_wrcnt  (fifo_wrcnt),
      .agc_data    (agc_data),
      .agc_load    (agc_load),
      .adc_ctrlword(adc_ctrlword),
      .adc_ldctrl  (adc_ldctrl),
      .adc_enable  (adc_enable),
      .busy        (busy),
      .overrun     (overrun),
      .agc_err     (agc_err),
      .sample_cnt  (sample_cnt),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   // Pulse monitor: tallies load pulses and the word visible while each is high.
   always @(posedge clk) begin
      #2;
      if (agc_load === 1'b1) begin
         n_load++;
         mon_agc = agc_data;
      end
      if (adc_ldctrl === 1'b1) begin
         n_ldctrl++;
         mon_cw = adc_ctrlword;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_reset_values();
      chk("rst_agc_data", 32'(agc_data), 32'h0AAA);
      chk("rst_ctrlword", 32'(adc_ctrlword), 32'h024);
      chk("rst_pulses", 32'({agc_load, adc_ldctrl}), 32'd0);
      chk("rst_enable", 32'(adc_enable), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_flags", 32'({overrun, agc_err}), 32'd0);
      chk("rst_sample_cnt", sample_cnt, 32'd0);
   endtask

   // Full start-to-ACQUIRE handshake; csn_low >= 4 and nbusy >= 2 so the exit
   // edges fall on the edge after each stimulus change.
   task automatic run_to_acquire(input logic [11:0] agc, input logic [9:0] cw,
                                 input int csn_low, input int nbusy, input bit poke);
      int loads0;
      int ld0;
      logic [21:0] exp_w;
      loads0 = n_load;
      ld0 = n_ldctrl;
      agc_level = agc;
      ctrlword = cw;
      start = 1'b1;
      exp_q.push_back({cw, agc});
      tick(1);
      start = 1'b0;
      chk("agc_load_pulse", 32'(agc_load), 32'd1);
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("flags_cleared", 32'({overrun, agc_err}), 32'd0);
      chk("cnt_cleared", sample_cnt, 32'd0);
      agc_csn = 1'b0;
      tick(csn_low);
      agc_csn = 1'b1;
      chk("ldctrl_not_early", 32'(adc_ldctrl), 32'd0);
      tick(1);
      chk("ldctrl_pulse", 32'(adc_ldctrl), 32'd1);
      exp_w = exp_q.pop_front();
      chk("agc_word", 32'(mon_agc), 32'(exp_w[11:0]));
      chk("ctrl_word", 32'(adc_ctrlword), 32'(exp_w[21:12]));
      chk("load_count", 32'(n_load - loads0), 32'd1);
      chk("ldctrl_count", 32'(n_ldctrl - ld0), 32'd1);
      adc_mbusy = 2'b11;
      tick(nbusy);
      adc_mbusy = 2'b00;
      if (poke) begin
         tick(3);
         start = 1'b1;
         agc_level = ~agc;
         tick(1);
         start = 1'b0;
         agc_level = agc;
         tick(SETTLE - 4);
      end else begin
         tick(SETTLE);
      end
      chk("enable_not_early", 32'(adc_enable), 32'd0);
      tick(1);
      chk("enable_on_time", 32'(adc_enable), 32'd1);
      chk("agc_data_held", 32'(agc_data), 32'(agc));
      chk("single_load", 32'(n_load - loads0), 32'd1);
   endtask

   initial begin
      int loads0;
      int ld0;
      // Reset
      #2 arstn = 1'b0;
      tick(2);
      chk_reset_values();
      arstn = 1'b1;

      // Nominal run with the fixed test-plan words
      run_to_acquire(12'h3FF, 10'h2A5, 20, 5, 1'b0);
      chk("agc_data_3ff", 32'(agc_data), 32'h3FF);
      chk("ctrl_2a5", 32'(adc_ctrlword), 32'h2A5);

      // 50 strobes, the last one coincident with stop
      exp_cnt = 0;
      for (int i = 0; i < 50; i++) begin
         tick($urandom_range(0, 3));
         fifo_wrcnt = WW'($urandom_range(0, HWM - 1));
         adc_valid = 1'b1;
         if (i == 49) stop = 1'b1;
         tick(1);
         adc_valid = 1'b0;
         stop = 1'b0;
         exp_cnt++;
         if (i == 24) chk("cnt_mid", sample_cnt, 32'(exp_cnt));
         if (i == 48) chk("enable_before_stop", 32'(adc_enable), 32'd1);
      end
      fifo_wrcnt = '0;
      chk("stop_enable", 32'(adc_enable), 32'd0);
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_cnt", sample_cnt, 32'(exp_cnt));
      chk("stop_no_overrun", 32'(overrun), 32'd0);

      // Stop while waiting on the AGC transfer
      ld0 = n_ldctrl;
      agc_level = 12'($urandom);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      agc_csn = 1'b0;
      tick(5);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      chk("stop_agcwait_busy", 32'(busy), 32'd0);
      agc_csn = 1'b1;
      tick(5);
      chk("stop_agcwait_no_ldctrl", 32'(n_ldctrl - ld0), 32'd0);
      chk("stop_agcwait_enable", 32'(adc_enable), 32'd0);

      // AGC timeout: csn never drops
      ld0 = n_ldctrl;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(TMO);
      chk("tmo_not_early", 32'({agc_err, busy}), 32'b01);
      tick(1);
      chk("tmo_err", 32'(agc_err), 32'd1);
      chk("tmo_idle", 32'(busy), 32'd0);
      tick(5);
      chk("tmo_no_enable", 32'(adc_enable), 32'd0);
      chk("tmo_no_ldctrl", 32'(n_ldctrl - ld0), 32'd0);

      // Overrun at the watermark (random words, random handshake timing)
      run_to_acquire(12'($urandom), 10'($urandom), $urandom_range(4, 20), $urandom_range(2, 6), 1'b0);
      for (int i = 0; i < 3; i++) begin
         adc_valid = 1'b1;
         tick(1);
         adc_valid = 1'b0;
         tick(1);
      end
      fifo_wrcnt = WW'(HWM - 1);
      tick(4);
      chk("hwm_minus1_enable", 32'(adc_enable), 32'd1);
      chk("hwm_minus1_overrun", 32'(overrun), 32'd0);
      fifo_wrcnt = WW'(HWM);
      adc_valid = 1'b1;
      tick(1);
      adc_valid = 1'b0;
      fifo_wrcnt = '0;
      chk("ovr_flag", 32'(overrun), 32'd1);
      chk("ovr_enable", 32'(adc_enable), 32'd0);
      chk("ovr_busy", 32'(busy), 32'd0);
      chk("ovr_cnt", sample_cnt, 32'd4);

      // Next start clears overrun; a start during SETTLE is ignored
      nsamples = 32'd8;
      run_to_acquire(12'($urandom), 10'($urandom), $urandom_range(4, 20), $urandom_range(2, 6), 1'b1);
      for (int i = 0; i < 8; i++) begin
         tick($urandom_range(0, 2));
         adc_valid = 1'b1;
         tick(1);
         adc_valid = 1'b0;
         if (i == 6) chk("limit_enable_before", 32'(adc_enable), 32'd1);
      end
`ifdef ACQ_SEQ_FRAME_LIMIT_EN
      chk("limit_enable_drop", 32'(adc_enable), 32'd0);
      chk("limit_busy", 32'(busy), 32'd0);
`else
      chk("nolimit_enable", 32'(adc_enable), 32'd1);
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
`endif
      chk("limit_cnt", sample_cnt, 32'd8);

      // Unlimited run past 1000 samples, then reset mid-acquisition
      nsamples = 32'd0;
      run_to_acquire(12'($urandom), 10'($urandom), $urandom_range(4, 20), $urandom_range(2, 6), 1'b0);
      adc_valid = 1'b1;
      tick(1005);
      adc_valid = 1'b0;
      chk("long_enable", 32'(adc_enable), 32'd1);
      chk("long_cnt", sample_cnt, 32'd1005);
      arstn = 1'b0;
      #1;
      chk_reset_values();
      tick(2);
      arstn = 1'b1;

      // start and stop together in IDLE
      loads0 = n_load;
      start = 1'b1;
      stop = 1'b1;
      tick(1);
      start = 1'b0;
      stop = 1'b0;
      chk("startstop_busy", 32'(busy), 32'd0);
      chk("startstop_load", 32'(agc_load), 32'd0);
      tick(3);
      chk("startstop_no_load", 32'(n_load - loads0), 32'd0);
      chk("startstop_idle", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
